operand_store: RTL and testbench
================================

# operand_store

Dual-bank operand memory that holds the X (data) and W (weight) vectors consumed by the dot-product controller. It is the responder side of the controller's read interface: it services `rd_x`/`rd_w` strobes with row address and element index, returning one word per bank with fixed one-cycle latency. A streaming load port with valid/ready handshake fills both banks before a computation is started.

## Interface
Parameters:
- `N`, 8, data word width
- `QW`, 2, row-address width; Q = 2^QW rows per bank
- `DW`, 2, element-index width; D = 2^DW elements per row

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `ld_start`  in  1  begin a load of X then W
- `ld_valid`  in  1  `ld_data` valid
- `ld_data`  in  N  load word
- `ld_ready`  out  1  load word accepted when `ld_valid & ld_ready`
- `ld_done`  out  1  one-cycle pulse, load complete
- `loaded`  out  1  level, both banks hold a complete load
- `rd_x`, `rd_w`  in  1  read strobes, X and W banks
- `addr_x`, `addr_w`  in  QW  row address
- `index_x`, `index_w`  in  DW  element index within row
- `data_x`, `data_w`  out  N  read data
- `rd_valid_x`, `rd_valid_w`  out  1  read data valid
- `rd_err`  out  1  read issued while `loaded`=0
- `rd_perr`  out  1  parity error (only with `OPSTORE_PARITY_EN`; otherwise tied 0)

## Operation
- FSM states: IDLE, LOAD_X, LOAD_W, DONE, READY.
- IDLE: `ld_ready`=0; `ld_start` -> LOAD_X, load pointer cleared.
- LOAD_X: `ld_ready`=1; each accepted word written to X at {addr,index} = pointer, row-major (index fastest). Pointer is QW+DW bits; when the word at pointer all-ones is accepted -> LOAD_W, pointer wraps to 0.
- LOAD_W: same for W bank; last accept -> DONE.
- DONE: `ld_ready`=0, `ld_done`=1 for exactly this cycle -> READY.
- READY: `loaded`=1. `ld_start` -> LOAD_X, `loaded` cleared the following cycle.
- `ld_start` in LOAD_X/LOAD_W/DONE ignored. `ld_valid` outside LOAD_X/LOAD_W ignored, no write.
- Reads are independent per bank and accepted in every state. A read with `loaded`=1 returns the stored word; with `loaded`=0 returns 0 and asserts `rd_err`.
- `data_x`/`data_w` hold their last value when no read is issued; `rd_valid_*` are 0 in cycles without a read.
- Memory contents are not cleared by reset.

## Timing
- Reset values: `ld_ready`=0, `ld_done`=0, `loaded`=0, `data_x`=`data_w`=0, `rd_valid_x`=`rd_valid_w`=0, `rd_err`=0, `rd_perr`=0; FSM in IDLE.
- Read latency exactly 1: strobe sampled at edge k -> data and `rd_valid_*`=1 during cycle k+1; `rd_err` aligned with the data.
- Back-to-back reads every cycle supported on both banks simultaneously.
- Load: one word per cycle max; full load is 2·Q·D accepted words; `ld_done` asserts the cycle after the last W accept, `loaded` one cycle after that.
- Read and `ld_start` in the same READY cycle: read is served from the existing contents, no `rd_err`.
- Reset mid-load: FSM returns to IDLE, `loaded`=0, partial contents kept but reads flag `rd_err` until a full load completes.

## Configuration
- `OPSTORE_PARITY_EN` defined: each stored word carries an even-parity bit computed at write. On read, mismatch asserts `rd_perr` aligned with `rd_valid_*`; data is still returned.
- Not defined: no parity storage; `rd_perr` constant 0.

## Test plan
- Reset, then `rd_x` addr 1 index 2 -> next cycle `rd_valid_x`=1, `data_x`=0, `rd_err`=1.
- Defaults, load X words 0x00..0x0F then W words 0x10..0x1F, `ld_valid` held 1 -> 32 accepts, `ld_done` pulse after the 32nd, `loaded`=1 the cycle after.
- After load, read X addr 2 index 3 and W addr 0 index 1 in the same cycle -> next cycle `data_x`=0x0B, `data_w`=0x11, both valid, `rd_err`=0.
- Load with `ld_valid` toggling every other cycle -> only handshaked words stored; read back all 32 matches.
- Assert `rst` after 10 W words -> IDLE, `loaded`=0, `ld_ready`=0; a subsequent read gives `rd_err`=1.
- With `OPSTORE_PARITY_EN`, force a stored bit flip at X[0][0] -> read returns data with `rd_perr`=1; unflipped word gives `rd_perr`=0.

Source files
------------

// File: rtl/operand_store_if.sv
// operand_store_if: load stream and dual-bank read bus for operand_store.
interface operand_store_if #(
    parameter int N  = 8,
    parameter int QW = 2,
    parameter int DW = 2
);
    logic          ld_start;
    logic          ld_valid;
    logic [N-1:0]  ld_data;
    logic          ld_ready;
    logic          ld_done;
    logic          loaded;
    logic          rd_x;
    logic          rd_w;
    logic [QW-1:0] addr_x;
    logic [QW-1:0] addr_w;
    logic [DW-1:0] index_x;
    logic [DW-1:0] index_w;
    logic [N-1:0]  data_x;
    logic [N-1:0]  data_w;
    logic          rd_valid_x;
    logic          rd_valid_w;
    logic          rd_err;
    logic          rd_perr;

    modport master (
        output ld_start, ld_valid, ld_data, rd_x, rd_w, addr_x, addr_w, index_x, index_w,
        input  ld_ready, ld_done, loaded, data_x, data_w, rd_valid_x, rd_valid_w, rd_err, rd_perr
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, rd_x, rd_w, addr_x, addr_w, index_x, index_w,
        output ld_ready, ld_done, loaded, data_x, data_w, rd_valid_x, rd_valid_w, rd_err, rd_perr
    );
endinterface

// File: rtl/operand_store.sv
// operand_store: dual-bank X/W operand memory with streaming load and 1-cycle reads.
// Define OPSTORE_PARITY_EN to store an even-parity bit per word and flag read mismatches.
module operand_store #(
    parameter int N  = 8,
    parameter int QW = 2,
    parameter int DW = 2
) (
    input logic            clk,
    input logic            rst,
    operand_store_if.slave bus
);
    localparam int AW    = QW + DW;
    localparam int DEPTH = 1 << AW;
`ifdef OPSTORE_PARITY_EN
    localparam int MW = N + 1;
`else
    localparam int MW = N;
`endif

    typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_W, DONE, READY} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic            acc, we_x, we_w, loaded;
    logic [MW-1:0]   mem_x [DEPTH];
    logic [MW-1:0]   mem_w [DEPTH];
    logic [MW-1:0]   wr_word, word_x, word_w;
    logic [N-1:0]    data_x_q, data_w_q;
    logic            valid_x_q, valid_w_q, err_q;

    assign loaded         = state_q == READY;
    assign bus.loaded     = loaded;
    assign bus.ld_ready   = state_q == LOAD_X || state_q == LOAD_W;
    assign bus.ld_done    = state_q == DONE;
    assign acc            = bus.ld_valid & bus.ld_ready;
    assign bus.data_x     = data_x_q;
    assign bus.data_w     = data_w_q;
    assign bus.rd_valid_x = valid_x_q;
    assign bus.rd_valid_w = valid_w_q;
    assign bus.rd_err     = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Pointer is {row, index}; it wraps to 0 after the last word of each bank.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we_x    = 1'b0;
        we_w    = 1'b0;
        case (state_q)
            IDLE, READY: begin
                if (bus.ld_start) begin
                    state_d = LOAD_X;
                    ptr_d   = '0;
                end
            end
            LOAD_X: begin
                if (acc) begin
                    we_x  = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    if (&ptr_q) state_d = LOAD_W;
                end
            end
            LOAD_W: begin
                if (acc) begin
                    we_w  = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    if (&ptr_q) state_d = DONE;
                end
            end
            DONE:    state_d = READY;
            default: state_d = IDLE;
        endcase
    end

`ifdef OPSTORE_PARITY_EN
    assign wr_word = {^bus.ld_data, bus.ld_data};
`else
    assign wr_word = bus.ld_data;
`endif

    always_ff @(posedge clk) begin
        if (we_x) mem_x[ptr_q] <= wr_word;
        if (we_w) mem_w[ptr_q] <= wr_word;
    end

    assign word_x = mem_x[{bus.addr_x, bus.index_x}];
    assign word_w = mem_w[{bus.addr_w, bus.index_w}];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_x_q  <= '0;
            data_w_q  <= '0;
            valid_x_q <= 1'b0;
            valid_w_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            valid_x_q <= bus.rd_x;
            valid_w_q <= bus.rd_w;
            err_q     <= (bus.rd_x | bus.rd_w) & ~loaded;
            if (bus.rd_x) data_x_q <= loaded ? word_x[N-1:0] : '0;
            if (bus.rd_w) data_w_q <= loaded ? word_w[N-1:0] : '0;
        end
    end

`ifdef OPSTORE_PARITY_EN
    logic perr_q;
    // A good word has even overall parity including its stored parity bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) perr_q <= 1'b0;
        else     perr_q <= loaded & ((bus.rd_x & ^word_x) | (bus.rd_w & ^word_w));
    end
    assign bus.rd_perr = perr_q;
`else
    assign bus.rd_perr = 1'b0;
`endif
endmodule

// File: tb/tb_operand_store.sv
// tb_operand_store: scoreboard bench for operand_store loads, reads and error flags.
module tb_operand_store;
    logic clk = 1'b0;
    logic rst = 1'b1;

    operand_store_if #(.N(8), .QW(2), .DW(2)) bus ();
    operand_store #(.N(8), .QW(2), .DW(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic       rx, rw;
        logic [7:0] dx, dw;
        logic       err, perr;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mx [16];
    logic [7:0] mw [16];
    bit         model_loaded = 0;
    bit         flip_x0 = 0;
    int         checks = 0;
    int         fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input bit rx, input bit rw, input int px, input int pw);
        exp_t e;
        bus.rd_x    = rx;
        bus.rd_w    = rw;
        bus.addr_x  = px[3:2];
        bus.index_x = px[1:0];
        bus.addr_w  = pw[3:2];
        bus.index_w = pw[1:0];
        e.rx   = rx;
        e.rw   = rw;
        e.dx   = model_loaded ? mx[px] : 8'h00;
        e.dw   = model_loaded ? mw[pw] : 8'h00;
        e.err  = (rx | rw) & ~model_loaded;
        e.perr = model_loaded & rx & flip_x0 & (px == 0);
        q.push_back(e);
        tick();
        bus.rd_x = 1'b0;
        bus.rd_w = 1'b0;
    endtask

    task automatic load(input bit start, input bit toggle, input logic [7:0] base, input int n);
        int cnt = 0;
        int cyc = 0;
        if (start) begin
            bus.ld_start = 1'b1;
            tick();
            bus.ld_start = 1'b0;
        end
        model_loaded = 0;
        while (cnt < n && cyc < 200) begin
            bus.ld_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.ld_data  = base + 8'(cnt);
            if (bus.ld_valid) begin
                chk("ld_ready_loading", bus.ld_ready, 1);
                if (cnt < 16) mx[cnt] = bus.ld_data;
                else          mw[cnt-16] = bus.ld_data;
                cnt++;
            end
            tick();
            cyc++;
        end
        bus.ld_valid = 1'b0;
        chk("load_count", cnt, n);
        if (n == 32) begin
            chk("ld_done_pulse", bus.ld_done, 1);
            chk("loaded_in_done", bus.loaded, 0);
            chk("ld_ready_done", bus.ld_ready, 0);
            tick();
            chk("ld_done_clear", bus.ld_done, 0);
            chk("loaded_set", bus.loaded, 1);
            model_loaded = 1;
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rd_valid_x || bus.rd_valid_w) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_valid: got x=%0b w=%0b expected none", bus.rd_valid_x, bus.rd_valid_w);
                end else begin
                    e = q.pop_front();
                    chk("rd_valid_x", bus.rd_valid_x, e.rx);
                    chk("rd_valid_w", bus.rd_valid_w, e.rw);
                    if (e.rx) chk("data_x", bus.data_x, e.dx);
                    if (e.rw) chk("data_w", bus.data_w, e.dw);
                    chk("rd_err", bus.rd_err, e.err);
                    chk("rd_perr", bus.rd_perr, e.perr);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bus.ld_start = 0; bus.ld_valid = 0; bus.ld_data = 0;
        bus.rd_x = 0; bus.rd_w = 0;
        bus.addr_x = 0; bus.addr_w = 0; bus.index_x = 0; bus.index_w = 0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ld_ready", bus.ld_ready, 0);
        chk("rst_ld_done", bus.ld_done, 0);
        chk("rst_loaded", bus.loaded, 0);
        chk("rst_data_x", bus.data_x, 0);
        chk("rst_data_w", bus.data_w, 0);
        chk("rst_rd_err", bus.rd_err, 0);
        chk("rst_rd_perr", bus.rd_perr, 0);
        // Unloaded read: addr 1 index 2
        rd(1, 0, 6, 0);
        bus.ld_valid = 1'b1;
        tick();
        bus.ld_valid = 1'b0;
        chk("idle_ignores_valid", bus.ld_ready, 0);
        load(1, 0, 8'h00, 32);
        rd(1, 1, 11, 1);
        for (int i = 0; i < 16; i++) rd(1, 1, i, 15 - i);
        rd(0, 1, 0, 7);
        // Read together with ld_start in READY is served from old contents
        bus.ld_start = 1'b1;
        rd(1, 1, 3, 12);
        bus.ld_start = 1'b0;
        model_loaded = 0;
        chk("loaded_cleared", bus.loaded, 0);
        load(0, 1, 8'h40, 32);
        for (int i = 0; i < 16; i++) rd(1, 1, i, i);
        load(1, 0, 8'h80, 26);
        rst = 1'b1;
        #1;
        chk("midrst_ld_ready", bus.ld_ready, 0);
        chk("midrst_loaded", bus.loaded, 0);
        tick();
        rst = 1'b0;
        model_loaded = 0;
        rd(1, 1, 5, 9);
        load(1, 0, 8'hA0, 32);
`ifdef OPSTORE_PARITY_EN
        dut.mem_x[0] = dut.mem_x[0] ^ 9'h001;
        mx[0] = mx[0] ^ 8'h01;
        flip_x0 = 1;
`endif
        rd(1, 0, 0, 0);
        rd(1, 1, 1, 2);
        repeat (3) tick();
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
